// File: rtl/calc_result_collector_if.sv
// calc_result_collector_if
//   Bundles the signals between the calculator adder pipeline, the result
//   collector and the downstream consumer (display/UART).
//
//   Producer side : issue_valid, result
//   Consumer side : out_data, out_valid, out_ready
//   Status        : fifo_count, overflow, result_total
//
//   Handshake on the consumer side: out_valid is high whenever the FIFO holds
//   an entry and out_data is that head entry. A transfer happens on a rising
//   edge where out_valid && out_ready are both high. out_valid never depends
//   combinationally on out_ready, and out_data stays stable until it is taken.
//
//   Modports: slave = the collector; master = whoever drives the pipeline and
//   consumes results (the testbench here).
`timescale 1ns/1ps
interface calc_result_collector_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic                     issue_valid;
  logic [DATA_W-1:0]        result;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic [15:0]              result_total;

  modport slave (
    input  issue_valid, result, out_ready,
    output out_data, out_valid, fifo_count, overflow, result_total
  );

  modport master (
    output issue_valid, result, out_ready,
    input  out_data, out_valid, fifo_count, overflow, result_total
  );
endinterface

// File: rtl/calc_result_collector.sv
// calc_result_collector
//   Downstream stage of the 3-stage calculator adder pipeline. A valid-tag
//   shift register, as long as the pipeline latency, follows each sampled
//   instruction through the adder; when a tagged slot leaves stage three its
//   8-bit result is written into a small first-word-fall-through FIFO that a
//   valid/ready consumer drains. Lost results set a sticky overflow flag and
//   accepted results are counted.
//
// Ports
//   one_MHz_clk  in   pipeline clock, all state on the rising edge
//   reset        in   asynchronous, active-high
//   bus          slave modport of calc_result_collector_if:
//                  issue_valid, result, out_ready          (in)
//                  out_data, out_valid, fifo_count,
//                  overflow, result_total                  (out)
//
// Parameters
//   LATENCY  edges from instruction sample to result valid at the adder (>=1)
//   DEPTH    FIFO entries (power of two, >=2)
//   DATA_W   result width
`timescale 1ns/1ps
module calc_result_collector #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8
) (
  input  logic                    one_MHz_clk,
  input  logic                    reset,
  calc_result_collector_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] tag;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               overflow_q;
  logic [15:0]        total_q;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic do_write;
  logic drop;

  // The tag for an instruction sampled at edge k reaches the last stage at
  // edge k+LATENCY-1, so the push happens at edge k+LATENCY, exactly when the
  // adder output belongs to that instruction.
  always_ff @(posedge one_MHz_clk or posedge reset) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag[0] <= bus.issue_valid;
      for (int i = 1; i < LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  assign push  = tag[LATENCY-1];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && bus.out_ready;

  // A full FIFO still accepts a push when the head leaves on the same edge:
  // the write lands on the slot being vacated (wr_ptr == rd_ptr when full).
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  // Storage is not reset; out_data is masked while empty so stale contents
  // are never visible.
  always_ff @(posedge one_MHz_clk) begin
    if (do_write) begin
      mem[wr_ptr] <= bus.result;
    end
  end

  always_ff @(posedge one_MHz_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      total_q    <= 16'd0;
    end else begin
      if (do_write) begin
        wr_ptr  <= wr_ptr + AW'(1);
        total_q <= total_q + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid    = !empty;
  assign bus.out_data     = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_count   = count;
  assign bus.overflow     = overflow_q;
  assign bus.result_total = total_q;
endmodule

// File: tb/tb_calc_result_collector.sv
`timescale 1ns/1ps
module tb_calc_result_collector;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 8;

  // ---------------- clock / reset ----------------
  logic one_MHz_clk = 1'b0;
  logic reset       = 1'b1;
  logic chk_en      = 1'b0;

  always #500 one_MHz_clk = ~one_MHz_clk;

  calc_result_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  calc_result_collector #(
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .one_MHz_clk(one_MHz_clk),
    .reset      (reset),
    .bus        (bus)
  );

  // ---------------- adder pipeline stand-in ----------------
  // Instruction word = four bytes to be summed; result appears at the
  // stage-three output LATENCY edges after sampling.
  logic [31:0] instr = 32'h0;
  logic [31:0] pipe [LATENCY];

  function automatic logic [7:0] bytesum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  always @(posedge one_MHz_clk) begin
    pipe[0] <= instr;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.result = bytesum(pipe[LATENCY-1]);

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
  } pend_t;

  logic [DATA_W-1:0] exp_q[$];
  pend_t             m_pend[$];
  int                m_edge = 0;
  logic              m_ovf = 1'b0;
  logic [15:0]       m_total = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: each real instruction becomes a result due LATENCY edges later;
  // on its due edge it joins the queue if there is room after this edge's pop.
  initial forever begin
    @(posedge one_MHz_clk or posedge reset);
    if (reset) begin
      exp_q.delete();
      m_pend.delete();
      m_ovf   = 1'b0;
      m_total = 16'd0;
    end else begin
      logic       arrive;
      logic       take;
      logic [7:0] v;
      pend_t      p;
      take   = (exp_q.size() > 0) && bus.out_ready;
      arrive = 1'b0;
      v      = 8'h0;
      if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
        arrive = 1'b1;
        v      = m_pend[0].val;
        void'(m_pend.pop_front());
      end
      if (take) void'(exp_q.pop_front());
      if (arrive) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(v);
          m_total = m_total + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (bus.issue_valid) begin
        p.due = m_edge + LATENCY;
        p.val = bytesum(instr);
        m_pend.push_back(p);
      end
      m_edge++;
    end
  end

  // Compare every cycle on the falling edge.
  initial forever begin
    @(negedge one_MHz_clk);
    if (chk_en) begin
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
      check("fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("result_total", 32'(bus.result_total), 32'(m_total));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives inputs for the next edge and
  // returns 1 ns after it.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic rdy);
    bus.issue_valid = iv;
    instr           = ins;
    bus.out_ready   = rdy;
    @(posedge one_MHz_clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(1'b0, 32'hDEAD_BEEF, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge one_MHz_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag_name);
    check({tag_name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag_name, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag_name, "_count"}, 32'(bus.fifo_count), 32'd0);
    check({tag_name, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag_name, "_total"}, 32'(bus.result_total), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] exp_t2 [4];
    logic [7:0] exp_t4 [4];
    exp_t2 = '{8'h04, 8'h08, 8'h0C, 8'h10};
    exp_t4 = '{8'h08, 8'h0C, 8'h10, 8'h14};

    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    instr           = 32'h0;
    reset           = 1'b1;
    repeat (3) @(posedge one_MHz_clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    check_zero("rst");

    // 1: single instruction, consumer always ready
    cyc(1'b1, 32'h0102_0304, 1'b1);
    idle(2, 1'b1);
    check("t1_early_valid", 32'(bus.out_valid), 32'd0);
    idle(1, 1'b1);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data", 32'(bus.out_data), 32'h0A);
    check("t1_total", 32'(bus.result_total), 32'd1);
    idle(1, 1'b1);
    check("t1_gone", 32'(bus.out_valid), 32'd0);

    // 2: fill, then overflow
    do_reset();
    cyc(1'b1, 32'h0101_0101, 1'b0);
    cyc(1'b1, 32'h0202_0202, 1'b0);
    cyc(1'b1, 32'h0303_0303, 1'b0);
    cyc(1'b1, 32'h0404_0404, 1'b0);
    idle(3, 1'b0);
    check("t2_count", 32'(bus.fifo_count), 32'd4);
    check("t2_head", 32'(bus.out_data), 32'h04);
    cyc(1'b1, 32'h0505_0505, 1'b0);
    idle(3, 1'b0);
    check("t2_ovf", 32'(bus.overflow), 32'd1);
    check("t2_count_full", 32'(bus.fifo_count), 32'd4);
    check("t2_head_kept", 32'(bus.out_data), 32'h04);
    check("t2_total", 32'(bus.result_total), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain", 32'(bus.out_data), 32'(exp_t2[i]));
      idle(1, 1'b1);
    end
    check("t2_empty", 32'(bus.out_valid), 32'd0);

    // 3: mod-256 wrap, overflow stays sticky
    cyc(1'b1, 32'hFF01_0000, 1'b0);
    cyc(1'b1, 32'h8080_8080, 1'b0);
    idle(3, 1'b0);
    check("t3_count", 32'(bus.fifo_count), 32'd2);
    check("t3_head", 32'(bus.out_data), 32'h00);
    check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
    check("t3_total", 32'(bus.result_total), 32'd6);
    idle(1, 1'b1);
    check("t3_second", 32'(bus.out_data), 32'h00);
    idle(1, 1'b1);
    check("t3_empty", 32'(bus.fifo_count), 32'd0);

    // 4: push into full FIFO on the same edge as a pop
    do_reset();
    cyc(1'b1, 32'h0101_0101, 1'b0);
    cyc(1'b1, 32'h0202_0202, 1'b0);
    cyc(1'b1, 32'h0303_0303, 1'b0);
    cyc(1'b1, 32'h0404_0404, 1'b0);
    cyc(1'b1, 32'h0505_0505, 1'b0);
    idle(2, 1'b0);
    check("t4_full", 32'(bus.fifo_count), 32'd4);
    idle(1, 1'b1);
    check("t4_count", 32'(bus.fifo_count), 32'd4);
    check("t4_ovf", 32'(bus.overflow), 32'd0);
    check("t4_total", 32'(bus.result_total), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", 32'(bus.out_data), 32'(exp_t4[i]));
      idle(1, 1'b1);
    end
    check("t4_empty", 32'(bus.out_valid), 32'd0);

    // 5: reset mid-flight with one entry stored and two in the pipe
    cyc(1'b1, 32'h0101_0101, 1'b0);
    idle(3, 1'b0);
    check("t5_pre", 32'(bus.fifo_count), 32'd1);
    cyc(1'b1, 32'h0202_0202, 1'b0);
    cyc(1'b1, 32'h0303_0303, 1'b0);
    #200;
    reset = 1'b1;
    #100;
    check_zero("t5_in_rst");
    @(posedge one_MHz_clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_no_valid", 32'(bus.out_valid), 32'd0);
      idle(1, 1'b1);
    end
    check_zero("t5_after");

    // 6: bubbles interleaved with real instructions
    do_reset();
    cyc(1'b1, 32'h0101_0101, 1'b0);
    cyc(1'b0, 32'hAAAA_AAAA, 1'b0);
    cyc(1'b1, 32'h0202_0202, 1'b0);
    cyc(1'b0, 32'hAAAA_AAAA, 1'b0);
    idle(3, 1'b0);
    check("t6_count", 32'(bus.fifo_count), 32'd2);
    check("t6_head", 32'(bus.out_data), 32'h04);
    check("t6_total", 32'(bus.result_total), 32'd2);
    idle(1, 1'b1);
    check("t6_second", 32'(bus.out_data), 32'h08);
    idle(1, 1'b1);
    check("t6_empty", 32'(bus.out_valid), 32'd0);
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
